// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl: iterative AES-256 key schedule, one 128-bit round key per cycle into a 15-entry store.
// Ports: clk, rst_n (async active-low); key_valid/key_ready/key[255:0] key-load handshake;
//        busy, done (1-cycle pulse), keys_valid status; rk_idx[3:0] in, rk[127:0] registered read out.
// Optional: define AES_KS_ZEROIZE_EN to add the zeroize input (clears store/window, returns to IDLE).
module aes256_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t         state_q, state_d;
  logic [127:0]   store_q [15];
  logic [127:0]   store_d [15];
  logic [255:0]   w_q, w_d;
  logic [3:0]     r_q, r_d;
  logic           keys_valid_q, keys_valid_d;
  logic           done_q, done_d;
  logic [127:0]   rk_q, rk_d;
  logic           zclr;
  logic           even;
  logic [31:0]    a7, sw_in, sub, t, n0, n1, n2, n3;
  logic [7:0]     rcon;
`ifdef AES_KS_ZEROIZE_EN
  assign zclr = zeroize;
`else
  assign zclr = 1'b0;
`endif
  // Even rounds rotate and add rcon; odd rounds (AES-256 only) apply SubWord alone.
  assign even  = ~r_q[0];
  assign a7    = w_q[31:0];
  assign sw_in = even ? {a7[23:0], a7[31:24]} : a7;
  assign sub   = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
  assign rcon  = 8'h01 << (r_q[3:1] - 3'd1);
  assign t     = sub ^ (even ? {rcon, 24'h0} : 32'h0);
  assign n0    = w_q[255:224] ^ t;
  assign n1    = w_q[223:192] ^ n0;
  assign n2    = w_q[191:160] ^ n1;
  assign n3    = w_q[159:128] ^ n2;
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    w_d          = w_q;
    r_d          = r_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    if (state_q == IDLE && key_valid) begin
      store_d[0]   = key[255:128];
      store_d[1]   = key[127:0];
      w_d          = key;
      r_d          = 4'd2;
      keys_valid_d = 1'b0;
      state_d      = EXPAND;
    end else if (state_q == EXPAND) begin
      store_d[r_q] = {n0, n1, n2, n3};
      w_d          = {w_q[127:0], n0, n1, n2, n3};
      r_d          = r_q + 4'd1;
      if (r_q == 4'd14) begin
        state_d      = IDLE;
        keys_valid_d = 1'b1;
        done_d       = 1'b1;
      end
    end
    if (zclr) begin
      store_d      = '{default: '0};
      w_d          = '0;
      r_d          = 4'd2;
      keys_valid_d = 1'b0;
      done_d       = 1'b0;
      state_d      = IDLE;
    end
    rk_d = (rk_idx <= 4'd14) ? store_q[rk_idx] : 128'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= '{default: '0};
      w_q          <= '0;
      r_q          <= 4'd2;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rk_q         <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      w_q          <= w_d;
      r_q          <= r_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      rk_q         <= rk_d;
    end
  end
  assign key_ready  = (state_q == IDLE);
  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk         = rk_q;
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// tb_aes256_key_sched_ctrl: directed self-checking bench for aes256_key_sched_ctrl.
module tb_aes256_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key = '0;
  logic         busy, done, keys_valid;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk;
`ifdef AES_KS_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  int n;
  localparam logic [255:0] KA = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KZ = 256'h0;
  localparam logic [127:0] A_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] A_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_RK2  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK3  = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;
  aes256_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_idx(rk_idx), .rk(rk)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rk_idx = idx;
    step();
    chk(tag, rk, exp);
  endtask
  // Counts edges until done rises, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input int start, output int cnt);
    cnt = start;
    do begin
      step();
      cnt++;
    end while (!done && cnt < 40);
  endtask
  initial begin
    #2;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_keys_valid", keys_valid, 0);
    chk("rst_rk", rk, 0);
    #10 rst_n = 1'b1;
    step();
    key = KA;
    key_valid = 1'b1;
    step();
    chk("acc_busy", busy, 1);
    chk("acc_key_ready", key_ready, 0);
    key = KZ;
    step();
    chk("exp_key_ready", key_ready, 0);
    key_valid = 1'b0;
    wait_done(1, n);
    chk("latency_a", n, 13);
    chk("done_a", done, 1);
    chk("kv_a", keys_valid, 1);
    rd("a_rk0", 4'd0, A_RK0);
    chk("done_pulse", done, 0);
    rd("a_rk1", 4'd1, A_RK1);
    rd("a_rk2", 4'd2, A_RK2);
    rd("a_rk3", 4'd3, A_RK3);
    rd("a_rk14", 4'd14, A_RK14);
    rd("a_rk15", 4'd15, 128'h0);
    key = KA;
    key_valid = 1'b1;
    step();
    key = KZ;
    wait_done(0, n);
    chk("b2b_latency1", n, 13);
    chk("b2b_kv1", keys_valid, 1);
    step();
    chk("b2b_accept_e14", busy, 1);
    chk("b2b_kv_drop", keys_valid, 0);
    chk("b2b_done_low", done, 0);
    key_valid = 1'b0;
    wait_done(0, n);
    chk("b2b_latency2", n, 13);
    rd("z_rk0", 4'd0, 128'h0);
    rd("z_rk2", 4'd2, Z_RK2);
    rd("z_rk3", 4'd3, Z_RK3);
    key = KA;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", key_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_kv", keys_valid, 0);
    chk("mid_rst_rk", rk, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) rd("mid_rst_store", 4'(i), 128'h0);
    key = KA;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    wait_done(0, n);
    chk("post_rst_latency", n, 13);
    rd("post_rst_rk2", 4'd2, A_RK2);
    rd("post_rst_rk14", 4'd14, A_RK14);
    chk("post_rst_kv", keys_valid, 1);
`ifdef AES_KS_ZEROIZE_EN
    zeroize = 1'b1;
    key = KA;
    key_valid = 1'b1;
    step();
    zeroize = 1'b0;
    key_valid = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_kv", keys_valid, 0);
    rd("zero_rk0", 4'd0, 128'h0);
    rd("zero_rk14", 4'd14, 128'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
